// File: rtl/cia_pkg.sv
// Shared definitions for the wide add/subtract sequencer: slice width,
// FSM state encoding and the slice-index width helper.
package cia_pkg;

    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of the slice index; at least one bit so NSLICE=1 still has a register.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cia.sv
// 8-bit carry-increment adder.
// The low half ripples; the high half is computed both as a+b and a+b+1,
// and the low-half carry selects between them.
// Ports:
//   a, b  in  slice operands
//   cin   in  carry in
//   sum   out slice sum
//   cout  out carry out of bit 7
module cia
    import cia_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    localparam int H = SLICE_W / 2;

    logic [H:0] lo;
    logic [H:0] hi_raw;
    logic [H:0] hi_inc;
    logic [H:0] hi;

    assign lo     = {1'b0, a[H-1:0]} + {1'b0, b[H-1:0]} + {{H{1'b0}}, cin};
    assign hi_raw = {1'b0, a[SLICE_W-1:H]} + {1'b0, b[SLICE_W-1:H]};
    assign hi_inc = hi_raw + {{H{1'b0}}, 1'b1};
    assign hi     = lo[H] ? hi_inc : hi_raw;

    assign sum  = {hi[H-1:0], lo[H-1:0]};
    assign cout = hi[H];

endmodule

// File: rtl/cia_wide_add_seq.sv
// Multi-cycle wide add/subtract sequencer. Operands of W = 8*NSLICE bits are
// pushed one 8-bit slice per cycle (LSB first) through a single shared
// carry-increment adder; a carry register chains the slices.
//
// state | meaning
// IDLE  | ready for operands (in_ready=1)
// RUN   | one slice per cycle through the adder
// DONE  | result held until out_valid && out_ready
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   operand handshake (a, b, cin, op_sub)
//   out_valid/out_ready result handshake (sum, cout, ovf)
//   busy                high in RUN or DONE
module cia_wide_add_seq
    import cia_pkg::*;
#(
    parameter int NSLICE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SLICE_W*NSLICE-1:0] a,
    input  logic [SLICE_W*NSLICE-1:0] b,
    input  logic                  cin,
    input  logic                  op_sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SLICE_W*NSLICE-1:0] sum,
    output logic                  cout,
    output logic                  ovf,
    output logic                  busy
);

    localparam int IW = idx_w(NSLICE);
    localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

    state_t state;
    state_t state_nx;

    logic [IW-1:0]                     idx;
    logic                              carry;
    logic [NSLICE-1:0][SLICE_W-1:0]    a_q;
    logic [NSLICE-1:0][SLICE_W-1:0]    b_q;
    logic [NSLICE-1:0][SLICE_W-1:0]    sum_q;
    logic                              cout_q;
    logic                              ovf_q;

    logic [SLICE_W-1:0] a_s;
    logic [SLICE_W-1:0] b_s;
    logic [SLICE_W-1:0] add_sum;
    logic               add_cout;

    logic accept;
    logic last;

    assign accept = in_valid && (state == ST_IDLE);
    assign last   = (state == ST_RUN) && (idx == LAST);

    always_comb begin
        a_s = '0;
        b_s = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx == IW'(i)) begin
                a_s = a_q[i];
                b_s = b_q[i];
            end
        end
    end

    cia u_cia (
        .a    (a_s),
        .b    (b_s),
        .cin  (carry),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (in_valid)  state_nx = ST_RUN;
            ST_RUN:  if (last)      state_nx = ST_DONE;
            ST_DONE: if (out_ready) state_nx = ST_IDLE;
            default:                state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
        busy      = (state == ST_RUN) || (state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            // Subtract is A + ~B + 1; the forced carry-in replaces cin.
            a_q   <= a;
            b_q   <= op_sub ? ~b : b;
            carry <= op_sub | cin;
            idx   <= '0;
        end else if (state == ST_RUN) begin
            for (int i = 0; i < NSLICE; i++) begin
                if (idx == IW'(i)) sum_q[i] <= add_sum;
            end
            carry <= add_cout;
            idx   <= last ? '0 : idx + IW'(1);
            if (last) begin
                cout_q <= add_cout;
                ovf_q  <= (a_q[NSLICE-1][SLICE_W-1] == b_q[NSLICE-1][SLICE_W-1]) &&
                          (add_sum[SLICE_W-1] != a_q[NSLICE-1][SLICE_W-1]);
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_cia_wide_add_seq.sv
module tb_cia_wide_add_seq;

    localparam int NOPS = 1000;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        in_valid4 = 0, in_ready4, cin4 = 0, op_sub4 = 0;
    logic        out_valid4, out_ready4 = 0, cout4, ovf4, busy4;
    logic [31:0] a4 = 0, b4 = 0, sum4;

    logic        in_valid1 = 0, in_ready1, cin1 = 0, op_sub1 = 0;
    logic        out_valid1, out_ready1 = 0, cout1, ovf1, busy1;
    logic [7:0]  a1 = 0, b1 = 0, sum1;

    int n_checks = 0;
    int n_fail = 0;

    exp_t q4[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    cia_wide_add_seq #(.NSLICE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .op_sub(op_sub4), .out_valid(out_valid4),
        .out_ready(out_ready4), .sum(sum4), .cout(cout4), .ovf(ovf4), .busy(busy4)
    );

    cia_wide_add_seq #(.NSLICE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .op_sub(op_sub1), .out_valid(out_valid1),
        .out_ready(out_ready1), .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1)
    );

    // Whole-width reference: one n-bit add, no slicing.
    function automatic exp_t ref_model(input logic [31:0] a, input logic [31:0] b,
                                       input logic cin, input logic sub, input int n);
        exp_t        e;
        logic [32:0] full;
        logic [31:0] m;
        logic [31:0] bb;
        logic [31:0] am;
        m    = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        am   = a & m;
        bb   = (sub ? ~b : b) & m;
        full = {1'b0, am} + {1'b0, bb} + {32'd0, (sub ? 1'b1 : cin)};
        e.sum  = full[31:0] & m;
        e.cout = full[n];
        e.ovf  = (am[n-1] == bb[n-1]) && (e.sum[n-1] != am[n-1]);
        return e;
    endfunction

    // Waits (from the post-edge phase) until out_valid4; lat = edges waited, -1 on timeout.
    task automatic wait_out4(output int lat);
        lat = 0;
        while (!out_valid4 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid4) lat = -1;
    endtask

    // Issues one op on dut4, waits for the result, captures it and completes the handshake.
    task automatic do_op4(input logic [31:0] a, input logic [31:0] b, input logic cin,
                          input logic sub, output logic [31:0] s, output logic c,
                          output logic o, output int lat);
        in_valid4 = 1; a4 = a; b4 = b; cin4 = cin; op_sub4 = sub;
        @(posedge clk); #1;
        in_valid4 = 0; a4 = 32'hDEAD_BEEF; b4 = 32'hCAFE_F00D; cin4 = ~cin; op_sub4 = ~sub;
        wait_out4(lat);
        s = sum4; c = cout4; o = ovf4;
        out_ready4 = 1;
        @(posedge clk); #1;
        out_ready4 = 0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (in_ready4 !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready4); end
        n_checks++; if (out_valid4 !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid4); end
        n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy4); end
        n_checks++; if ({sum4, cout4, ovf4} !== 34'd0) begin n_fail++; $display("FAIL rst_result: got %h/%b/%b expected 0/0/0", sum4, cout4, ovf4); end
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        n_checks++; if (in_ready4 !== 1'b1 || in_ready1 !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b%b expected 11", in_ready4, in_ready1); end
    endtask

    task automatic test_directed();
        logic [31:0] s; logic c, o; int lat;
        do_op4(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, s, c, o, lat);
        n_checks++; if ({s, c, o} !== {32'h0000_0100, 1'b0, 1'b0}) begin n_fail++; $display("FAIL add_ff_1: got %h/%b/%b expected 00000100/0/0", s, c, o); end
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL latency: got %0d expected 4", lat); end
        do_op4(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, s, c, o, lat);
        n_checks++; if ({s, c, o} !== {32'h0000_0000, 1'b1, 1'b0}) begin n_fail++; $display("FAIL ripple_all: got %h/%b/%b expected 00000000/1/0", s, c, o); end
        do_op4(32'd5, 32'd7, 1'b0, 1'b1, s, c, o, lat);
        n_checks++; if ({s, c, o} !== {32'hFFFF_FFFE, 1'b0, 1'b0}) begin n_fail++; $display("FAIL sub_5_7: got %h/%b/%b expected fffffffe/0/0", s, c, o); end
        do_op4(32'h8000_0000, 32'd1, 1'b1, 1'b1, s, c, o, lat);
        n_checks++; if ({s, c, o} !== {32'h7FFF_FFFF, 1'b1, 1'b1}) begin n_fail++; $display("FAIL sub_ovf: got %h/%b/%b expected 7fffffff/1/1", s, c, o); end
    endtask

    task automatic test_backpressure();
        int lat;
        in_valid4 = 1; a4 = 32'h10; b4 = 32'h20; cin4 = 0; op_sub4 = 0;
        @(posedge clk); #1;
        in_valid4 = 0;
        wait_out4(lat);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL bp_latency: got %0d expected 4", lat); end
        for (int k = 0; k < 5; k++) begin
            in_valid4 = 1; a4 = 32'h1000; b4 = 32'h1; cin4 = 0; op_sub4 = 0;
            n_checks++; if ({out_valid4, sum4, cout4, ovf4} !== {1'b1, 32'h30, 1'b0, 1'b0}) begin n_fail++; $display("FAIL bp_hold: got %b/%h/%b/%b expected 1/00000030/0/0", out_valid4, sum4, cout4, ovf4); end
            n_checks++; if (in_ready4 !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", in_ready4); end
            @(posedge clk); #1;
        end
        out_ready4 = 1;
        @(posedge clk); #1;
        out_ready4 = 0;
        n_checks++; if ({out_valid4, in_ready4} !== 2'b01) begin n_fail++; $display("FAIL bp_release: got %b%b expected 01", out_valid4, in_ready4); end
        @(posedge clk); #1;
        in_valid4 = 0;
        n_checks++; if (busy4 !== 1'b1) begin n_fail++; $display("FAIL bp_pending_taken: got %b expected 1", busy4); end
        wait_out4(lat);
        n_checks++; if ({sum4, cout4, ovf4} !== {32'h1001, 1'b0, 1'b0}) begin n_fail++; $display("FAIL bp_second: got %h/%b/%b expected 00001001/0/0", sum4, cout4, ovf4); end
        out_ready4 = 1;
        @(posedge clk); #1;
        out_ready4 = 0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] s; logic c, o; int lat;
        in_valid4 = 1; a4 = 32'h0F0F_0F0F; b4 = 32'h0101_0101; cin4 = 0; op_sub4 = 0;
        @(posedge clk); #1;
        in_valid4 = 0;
        repeat (2) begin @(posedge clk); #1; end
        n_checks++; if (busy4 !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b expected 1", busy4); end
        rst_n = 0;
        #1;
        n_checks++; if ({out_valid4, busy4, in_ready4} !== 3'b001) begin n_fail++; $display("FAIL mid_abort_ctl: got %b%b%b expected 001", out_valid4, busy4, in_ready4); end
        n_checks++; if (sum4 !== 32'h0) begin n_fail++; $display("FAIL mid_sum_clear: got %h expected 00000000", sum4); end
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        n_checks++; if (in_ready4 !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b expected 1", in_ready4); end
        do_op4(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, s, c, o, lat);
        n_checks++; if ({s, c, o} !== {32'h2345_6789, 1'b0, 1'b0}) begin n_fail++; $display("FAIL mid_next_op: got %h/%b/%b expected 23456789/0/0", s, c, o); end
    endtask

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        fork
            begin : drv4
                logic [31:0] ra, rb; logic rc, rs; int waited;
                for (int i = 0; i < NOPS; i++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    ra = pick32(); rb = pick32(); rc = 1'($urandom); rs = 1'($urandom);
                    in_valid4 = 1; a4 = ra; b4 = rb; cin4 = rc; op_sub4 = rs;
                    waited = 0;
                    while (!in_ready4 && waited < 200) begin @(posedge clk); #1; waited++; end
                    n_checks++;
                    if (!in_ready4) begin n_fail++; $display("FAIL rnd4_accept_timeout: got in_ready %b expected 1", in_ready4); break; end
                    q4.push_back(ref_model(ra, rb, rc, rs, 32));
                    @(posedge clk); #1;
                    in_valid4 = 0; a4 = $urandom; b4 = $urandom; cin4 = ~rc; op_sub4 = ~rs;
                end
            end
            begin : mon4
                int got, cyc; exp_t e;
                got = 0; cyc = 0;
                while (got < NOPS && cyc < 40000) begin
                    out_ready4 = 1'($urandom);
                    if (out_valid4 && out_ready4) begin
                        n_checks++;
                        if (q4.size() == 0) begin n_fail++; $display("FAIL rnd4_unexpected: got result %h expected none", sum4); end
                        else begin
                            e = q4.pop_front();
                            if (sum4 !== e.sum) n_fail++;
                            if (sum4 !== e.sum) $display("FAIL rnd4_sum: got %h expected %h", sum4, e.sum);
                            n_checks++; if (cout4 !== e.cout) begin n_fail++; $display("FAIL rnd4_cout: got %b expected %b", cout4, e.cout); end
                            n_checks++; if (ovf4 !== e.ovf) begin n_fail++; $display("FAIL rnd4_ovf: got %b expected %b", ovf4, e.ovf); end
                        end
                        got++;
                    end
                    @(posedge clk); #1;
                    cyc++;
                end
                out_ready4 = 0;
                n_checks++; if (got != NOPS) begin n_fail++; $display("FAIL rnd4_count: got %0d expected %0d", got, NOPS); end
            end
            begin : drv1
                logic [7:0] ra, rb; logic rc, rs; int waited;
                for (int i = 0; i < NOPS; i++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    ra = 8'(pick32()); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
                    in_valid1 = 1; a1 = ra; b1 = rb; cin1 = rc; op_sub1 = rs;
                    waited = 0;
                    while (!in_ready1 && waited < 200) begin @(posedge clk); #1; waited++; end
                    n_checks++;
                    if (!in_ready1) begin n_fail++; $display("FAIL rnd1_accept_timeout: got in_ready %b expected 1", in_ready1); break; end
                    q1.push_back(ref_model({24'd0, ra}, {24'd0, rb}, rc, rs, 8));
                    @(posedge clk); #1;
                    in_valid1 = 0; a1 = 8'($urandom); b1 = 8'($urandom); cin1 = ~rc; op_sub1 = ~rs;
                end
            end
            begin : mon1
                int got, cyc; exp_t e;
                got = 0; cyc = 0;
                while (got < NOPS && cyc < 40000) begin
                    out_ready1 = 1'($urandom);
                    if (out_valid1 && out_ready1) begin
                        n_checks++;
                        if (q1.size() == 0) begin n_fail++; $display("FAIL rnd1_unexpected: got result %h expected none", sum1); end
                        else begin
                            e = q1.pop_front();
                            if (sum1 !== e.sum[7:0]) begin n_fail++; $display("FAIL rnd1_sum: got %h expected %h", sum1, e.sum[7:0]); end
                            n_checks++; if (cout1 !== e.cout) begin n_fail++; $display("FAIL rnd1_cout: got %b expected %b", cout1, e.cout); end
                            n_checks++; if (ovf1 !== e.ovf) begin n_fail++; $display("FAIL rnd1_ovf: got %b expected %b", ovf1, e.ovf); end
                        end
                        got++;
                    end
                    @(posedge clk); #1;
                    cyc++;
                end
                out_ready1 = 0;
                n_checks++; if (got != NOPS) begin n_fail++; $display("FAIL rnd1_count: got %0d expected %0d", got, NOPS); end
            end
        join
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
